// File: rtl/preadd_b1_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : preadd_b1_stage_pkg
// Description : Shared DSP constants for the pre-adder / B1 pipeline stages:
//               operand and opcode widths, OPMODE bit positions and the
//               modulo-2^18 pre-adder helper.
// Revision    : 1.0 - initial release
// ============================================================================
package preadd_b1_stage_pkg;

    localparam int DSP_W      = 18;  // B / D operand width
    localparam int OPM_W      = 8;   // OPMODE width
    localparam int OPM_SUB    = 6;   // 1 = D - B, 0 = D + B
    localparam int OPM_PREADD = 4;   // 1 = feed pre-adder result into B1

    // Add or subtract at operand width; carry/borrow fall off the top.
    function automatic logic [DSP_W-1:0] preadd_calc(
        input logic [DSP_W-1:0] a,
        input logic [DSP_W-1:0] b,
        input logic             sub
    );
        logic [DSP_W-1:0] res;
        res = sub ? (a - b) : (a + b);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/preadd_b1_stage_ce_reg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_ce_reg
// Description : Width-parameterised register with clock enable and
//               asynchronous active-low reset. REG_EN=0 removes the flop and
//               passes i_d straight to o_q.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset (clears to 0)
//               i_ce  - load enable
//               i_d   - data in
//               o_q   - registered (or bypassed) data out
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_ce_reg #(
    parameter int WIDTH  = 18,
    parameter int REG_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (REG_EN != 0) begin : g_reg
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        always_comb begin
            data_d = data_q;
            if (i_ce) begin
                data_d = i_d;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign o_q = data_q;
    end else begin : g_bypass
        assign o_q = i_d;
    end

endmodule
`default_nettype wire

// File: rtl/preadd_b1_stage.sv
`default_nettype none
// ============================================================================
// Module      : preadd_b1_stage
// Description : Optional D / OPMODE input registers, 18-bit pre-adder
//               (D +/- B) and optional B1 register feeding the multiplier B
//               operand and the B cascade output.
// Ports       : CLK, RSTN           - clock, async active-low reset
//               CED, CEOPMODE, CEB  - enables for the D, OPMODE, B1 registers
//               D, B_mux0           - pre-adder operands
//               OPMODE              - bit 6 subtract, bit 4 pre-adder enable
//               OPMODE_mux          - selected OPMODE for downstream stages
//               B1_mux, BCOUT       - multiplier B operand / cascade copy
// Revision    : 1.0 - initial release
// ============================================================================
module preadd_b1_stage
    import preadd_b1_stage_pkg::*;
#(
    parameter int DREG      = 1,
    parameter int OPMODEREG = 1,
    parameter int B1REG     = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CED,
    input  logic             CEOPMODE,
    input  logic             CEB,
    input  logic [DSP_W-1:0] D,
    input  logic [DSP_W-1:0] B_mux0,
    input  logic [OPM_W-1:0] OPMODE,
    output logic [OPM_W-1:0] OPMODE_mux,
    output logic [DSP_W-1:0] B1_mux,
    output logic [DSP_W-1:0] BCOUT
);

    logic [DSP_W-1:0] w_d_sel;
    logic [DSP_W-1:0] w_preadd;
    logic [DSP_W-1:0] w_b1_in;

    dsp_ce_reg #(
        .WIDTH  (DSP_W),
        .REG_EN (DREG)
    ) u_d_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .i_ce  (CED),
        .i_d   (D),
        .o_q   (w_d_sel)
    );

    dsp_ce_reg #(
        .WIDTH  (OPM_W),
        .REG_EN (OPMODEREG)
    ) u_opmode_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .i_ce  (CEOPMODE),
        .i_d   (OPMODE),
        .o_q   (OPMODE_mux)
    );

    // The current OPMODE_mux steers whatever B1_in is sampled this cycle;
    // the opcode is deliberately not delayed to match the D pipeline.
    always_comb begin
        w_preadd = preadd_calc(w_d_sel, B_mux0, OPMODE_mux[OPM_SUB]);
        w_b1_in  = B_mux0;
        if (OPMODE_mux[OPM_PREADD]) begin
            w_b1_in = w_preadd;
        end
    end

    dsp_ce_reg #(
        .WIDTH  (DSP_W),
        .REG_EN (B1REG)
    ) u_b1_reg (
        .clk   (CLK),
        .rst_n (RSTN),
        .i_ce  (CEB),
        .i_d   (w_b1_in),
        .o_q   (B1_mux)
    );

    assign BCOUT = B1_mux;

endmodule
`default_nettype wire

// File: tb/tb_preadd_b1_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_preadd_b1_stage
// Description : Self-checking bench for preadd_b1_stage. A fully registered
//               instance and a fully combinational instance share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preadd_b1_stage;
    import preadd_b1_stage_pkg::*;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             CED, CEOPMODE, CEB;
    logic [DSP_W-1:0] D, B_mux0;
    logic [OPM_W-1:0] OPMODE;

    logic [OPM_W-1:0] opm_a, opm_b;
    logic [DSP_W-1:0] b1_a, b1_b, bc_a, bc_b;

    preadd_b1_stage dut_a (
        .CLK(CLK), .RSTN(RSTN), .CED(CED), .CEOPMODE(CEOPMODE), .CEB(CEB),
        .D(D), .B_mux0(B_mux0), .OPMODE(OPMODE),
        .OPMODE_mux(opm_a), .B1_mux(b1_a), .BCOUT(bc_a)
    );

    preadd_b1_stage #(.DREG(0), .OPMODEREG(0), .B1REG(0)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .CED(CED), .CEOPMODE(CEOPMODE), .CEB(CEB),
        .D(D), .B_mux0(B_mux0), .OPMODE(OPMODE),
        .OPMODE_mux(opm_b), .B1_mux(b1_b), .BCOUT(bc_b)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what each register should hold.
    logic [DSP_W-1:0] m_qd, m_qb1;
    logic [OPM_W-1:0] m_qop;

    // B1 input from the rules: pass B unless pre-adder enabled; wrap mod 2^18.
    function automatic logic [DSP_W-1:0] ref_b1(input logic [DSP_W-1:0] d,
                                                 input logic [DSP_W-1:0] b,
                                                 input logic [OPM_W-1:0] op);
        int s;
        if (!op[4]) return b;
        if (op[6]) s = int'(d) - int'(b);
        else       s = int'(d) + int'(b);
        return DSP_W'(s & 32'h3FFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One rising edge of the model, then return at the following falling edge.
    task automatic tick();
        logic [DSP_W-1:0] nb1;
        @(posedge CLK);
        if (RSTN) begin
            nb1 = CEB ? ref_b1(m_qd, B_mux0, m_qop) : m_qb1;
            if (CED)      m_qd  = D;
            if (CEOPMODE) m_qop = OPMODE;
            m_qb1 = nb1;
        end
        @(negedge CLK);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".b1_a"},  32'(b1_a),  32'(m_qb1));
        check({tag, ".bc_a"},  32'(bc_a),  32'(m_qb1));
        check({tag, ".opm_a"}, 32'(opm_a), 32'(m_qop));
        check({tag, ".b1_b"},  32'(b1_b),  32'(ref_b1(D, B_mux0, OPMODE)));
        check({tag, ".bc_b"},  32'(bc_b),  32'(ref_b1(D, B_mux0, OPMODE)));
        check({tag, ".opm_b"}, 32'(opm_b), 32'(OPMODE));
    endtask

    typedef struct {
        logic [DSP_W-1:0] d;
        logic [DSP_W-1:0] b;
        logic [OPM_W-1:0] op;
        logic [DSP_W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{d: 18'h00010, b: 18'h00003, op: 8'h10, exp: 18'h00013};
        vecs[1] = '{d: 18'h00005, b: 18'h00007, op: 8'h50, exp: 18'h3FFFE};
        vecs[2] = '{d: 18'h00003, b: 18'h2AAAA, op: 8'h00, exp: 18'h2AAAA};
        vecs[3] = '{d: 18'h3FFFF, b: 18'h00001, op: 8'h10, exp: 18'h00000};
        vecs[4] = '{d: 18'h00000, b: 18'h00001, op: 8'h50, exp: 18'h3FFFF};
        vecs[5] = '{d: 18'h11111, b: 18'h12345, op: 8'h40, exp: 18'h12345};

        // Power-on reset.
        RSTN = 1'b0; CED = 1'b1; CEOPMODE = 1'b1; CEB = 1'b1;
        D = 18'h00010; B_mux0 = 18'h00003; OPMODE = 8'h10;
        m_qd = '0; m_qb1 = '0; m_qop = '0;
        #3;
        check("rst.b1_a",  32'(b1_a),  0);
        check("rst.bc_a",  32'(bc_a),  0);
        check("rst.opm_a", 32'(opm_a), 0);
        check("rst.b1_b",  32'(b1_b),  32'h13);
        @(negedge CLK);
        RSTN = 1'b1;

        // Directed vectors: hold each pattern for two edges.
        for (int i = 0; i < 6; i++) begin
            D = vecs[i].d; B_mux0 = vecs[i].b; OPMODE = vecs[i].op;
            #1;
            check($sformatf("vec%0d.comb", i), 32'(b1_b), 32'(vecs[i].exp));
            tick();
            check_all($sformatf("vec%0d.e1", i));
            tick();
            check($sformatf("vec%0d.b1", i), 32'(b1_a), 32'(vecs[i].exp));
            check($sformatf("vec%0d.bc", i), 32'(bc_a), 32'(vecs[i].exp));
            check_all($sformatf("vec%0d.e2", i));
        end

        // B path has one cycle of latency when the pre-adder is off.
        OPMODE = 8'h00; tick();
        B_mux0 = 18'h15555; D = 18'h00777; tick();
        check("blat.b1", 32'(b1_a), 32'h15555);
        check_all("blat");

        // Hold with CEB=0 while everything else changes.
        D = 18'h00010; B_mux0 = 18'h00003; OPMODE = 8'h10;
        tick(); tick();
        check("hold.load", 32'(b1_a), 32'h13);
        CEB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D = 18'($urandom); B_mux0 = 18'($urandom); OPMODE = 8'($urandom);
            tick();
            check($sformatf("hold%0d", i), 32'(b1_a), 32'h13);
            check_all($sformatf("hold%0d", i));
        end
        CEB = 1'b1;

        // Asynchronous reset pulse between edges.
        D = 18'h00020; B_mux0 = 18'h00004; OPMODE = 8'h10;
        tick();
        #2 RSTN = 1'b0;
        #1;
        check("arst.b1",   32'(b1_a), 0);
        check("arst.opm",  32'(opm_a), 0);
        check("arst.qd",   32'(dut_a.w_d_sel), 0);
        check("arst.comb", 32'(b1_b), 32'h24);
        m_qd = '0; m_qb1 = '0; m_qop = '0;
        #1 RSTN = 1'b1;
        tick();
        check("rel.b1",  32'(b1_a), 32'h4);
        check("rel.opm", 32'(opm_a), 32'h10);
        check("rel.qd",  32'(dut_a.w_d_sel), 32'h20);
        tick();
        check("rel2.b1", 32'(b1_a), 32'h24);
        check_all("rel2");

        // Randomised run against the model.
        for (int i = 0; i < 300; i++) begin
            CED = 1'($urandom); CEOPMODE = 1'($urandom); CEB = 1'($urandom);
            D = 18'($urandom); B_mux0 = 18'($urandom);
            case ($urandom_range(0, 4))
                0: OPMODE = 8'h00;
                1: OPMODE = 8'h10;
                2: OPMODE = 8'h40;
                3: OPMODE = 8'h50;
                default: OPMODE = 8'($urandom);
            endcase
            #1;
            check("rnd.comb", 32'(b1_b), 32'(ref_b1(D, B_mux0, OPMODE)));
            tick();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
